ctrl_fsm: RTL



---
 rtl/sisc_pkg.sv | 55 +++++
 rtl/ctrl_fsm.sv | 97 +++++++++
 2 files changed

// File: rtl/sisc_pkg.sv
// sisc_pkg: shared definitions for the SISC processor.
// Holds the opcode constants, the control FSM state encodings, the alu_op
// field layout shared between the control unit and the ALU, and the
// instruction decode helper.
package sisc_pkg;

   // Opcodes (instruction register bits [31:28])
   localparam logic [3:0] NOP = 4'b0000;
   localparam logic [3:0] ALU = 4'b0001;
   localparam logic [3:0] ALX = 4'b0010;
   localparam logic [3:0] HLT = 4'b1111;

   // Control FSM states; encodings are visible on the debug state output
   typedef enum logic [2:0] {
      StStart0    = 3'd0,
      StStart1    = 3'd1,
      StFetch     = 3'd2,
      StDecode    = 3'd3,
      StExecute   = 3'd4,
      StMem       = 3'd5,
      StWriteback = 3'd6,
      StHalt      = 3'd7
   } state_e;

   // alu_op layout: [3:1] operation select, [0] status-register update request
   typedef struct packed {
      logic [2:0] func;
      logic       status;
   } alu_op_t;

   // Decoded instruction: valid marks an instruction that writes the register file
   typedef struct packed {
      logic       valid;
      logic [2:0] func;
      logic       status;
   } dec_t;

   // Anything that is not a register/immediate ALU op or an ALX op with
   // mm[2:0] >= 2 decodes as a NOP (all fields zero).
   function automatic dec_t decode_instr(input logic [3:0] opcode, input logic [3:0] mm);
      dec_t d;
      d = '0;
      if (opcode == ALU) begin
         d.valid  = 1'b1;
         d.func   = {2'b00, mm[3]};
         d.status = 1'b1;
      end else if (opcode == ALX && mm[2:1] != 2'b00) begin
         d.valid  = 1'b1;
         d.func   = mm[2:0];
         d.status = ~mm[3];
      end
      return d;
   endfunction

endpackage

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control unit for the SISC processor.
// Sequences each instruction through FETCH, DECODE, EXECUTE, MEM and
// WRITEBACK and decodes opcode/mm into ALU and register-file controls.
// Only the state is registered; all outputs decode combinationally from the
// state plus opcode/mm.
// Ports:
//   clk      - system clock
//   rst_f    - synchronous active-low reset
//   opcode   - instruction register bits [31:28]
//   mm       - instruction register bits [27:24] (mode field)
//   ir_load  - instruction register load strobe (FETCH only)
//   pc_write - PC increment strobe (FETCH only)
//   alu_op   - ALU operation; [3:1] select, [0] status update (EXECUTE only)
//   rf_we    - register file write enable (WRITEBACK, valid instructions)
//   wb_sel   - writeback source select, always 0 (alu_result)
//   halt     - high while halted
//   state    - current state, for debug
module ctrl_fsm
   import sisc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_f,
   input  logic [3:0] opcode,
   input  logic [3:0] mm,
   output logic       ir_load,
   output logic       pc_write,
   output logic [3:0] alu_op,
   output logic       rf_we,
   output logic       wb_sel,
   output logic       halt,
   output logic [2:0] state
);

   state_e  state_q, state_d;
   dec_t    dec;
   alu_op_t alu_op_s;

   always_ff @(posedge clk) begin
      if (!rst_f) begin
         state_q <= StStart0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StStart0:    state_d = StStart1;
         StStart1:    state_d = StFetch;
         StFetch:     state_d = StDecode;
         StDecode:    state_d = (opcode == HLT) ? StHalt : StExecute;
         StExecute:   state_d = StMem;
         StMem:       state_d = StWriteback;
         StWriteback: state_d = StFetch;
         StHalt:      state_d = StHalt;
         default:     state_d = StStart0;
      endcase
   end

   assign dec = decode_instr(opcode, mm);

   always_comb begin
      ir_load  = 1'b0;
      pc_write = 1'b0;
      alu_op_s = '0;
      rf_we    = 1'b0;
      halt     = 1'b0;
      unique case (state_q)
         StFetch: begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
         end
         StDecode, StMem: begin
            alu_op_s.func = dec.func;
         end
         StExecute: begin
            // Status request only here so the status register updates once
            alu_op_s.func   = dec.func;
            alu_op_s.status = dec.status;
         end
         StWriteback: begin
            alu_op_s.func = dec.func;
            rf_we         = dec.valid;
         end
         StHalt: begin
            halt = 1'b1;
         end
         default: ;
      endcase
   end

   assign alu_op = alu_op_s;
   assign wb_sel = 1'b0;
   assign state  = state_q;

endmodule
